// File: rtl/secded_dec_72_64.sv
// Two-stage SECDED (72,64) decoder: stage 1 computes syndrome/parity, stage 2 corrects.
// Keeps saturating SEC/DED counters and a sticky first-DED address for scrub/status logic.
module secded_dec_72_64 #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [71:0]       DatatoDecoder,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_sec,
  output logic              out_ded,
  output logic [7:0]        out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              ded_seen,
  output logic [ADDR_W-1:0] ded_addr
);

  // Codeword position of data bit idx: the (idx+1)th non-power-of-two index in 1..71.
  function automatic logic [6:0] data_pos(input int idx);
    int         n;
    logic [6:0] r;
    n = 0;
    r = '0;
    for (int p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) r = 7'(p);
        n++;
      end
    end
    return r;
  endfunction

  // Handshake: a word moves on an edge where valid && ready. Stage 2 frees up when it is
  // empty or the consumer takes it; stage 1 frees up when empty or moving into stage 2.
  logic s2_ready;

  logic              s1_valid_q;
  logic [63:0]       s1_data_q;
  logic [6:0]        s1_syn_q;
  logic              s1_par_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic              out_valid_q;
  logic [63:0]       out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_sec_q;
  logic              out_ded_q;
  logic [7:0]        out_syn_q;

  logic [CNT_W-1:0]  sec_cnt_q;
  logic [CNT_W-1:0]  ded_cnt_q;
  logic              ded_seen_q;
  logic [ADDR_W-1:0] ded_addr_q;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  // Check bit j lives at position 2^j, so the check bits contribute check[6:0] directly.
  logic [6:0] syn_d;
  logic       par_d;
  always_comb begin
    syn_d = DatatoDecoder[70:64];
    for (int i = 0; i < 64; i++) begin
      if (DatatoDecoder[i]) syn_d = syn_d ^ data_pos(i);
    end
    par_d = ^DatatoDecoder;
  end

  logic [63:0] corr_d;
  logic        sec_d;
  logic        ded_d;
  always_comb begin
    sec_d  = s1_par_q && (s1_syn_q <= 7'd71);
    ded_d  = (s1_par_q && (s1_syn_q > 7'd71)) || (!s1_par_q && (s1_syn_q != 7'd0));
    corr_d = s1_data_q;
    for (int i = 0; i < 64; i++) begin
      if (sec_d && (s1_syn_q == data_pos(i))) corr_d[i] = ~s1_data_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_syn_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_data_q <= DatatoDecoder[63:0];
          s1_syn_q  <= syn_d;
          s1_par_q  <= par_d;
          s1_addr_q <= in_addr;
        end
      end
      if (s2_ready) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= corr_d;
          out_addr_q <= s1_addr_q;
          out_sec_q  <= sec_d;
          out_ded_q  <= ded_d;
          out_syn_q  <= {s1_par_q, s1_syn_q};
        end
      end
    end
  end

  // Events are counted only when the consumer takes the word; a clear on that edge wins.
  logic out_fire;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      ded_seen_q <= 1'b0;
      ded_addr_q <= '0;
    end else if (cnt_clr) begin
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      ded_seen_q <= 1'b0;
      ded_addr_q <= '0;
    end else if (out_fire) begin
      if (out_sec_q && !(&sec_cnt_q)) sec_cnt_q <= sec_cnt_q + CNT_W'(1);
      if (out_ded_q && !(&ded_cnt_q)) ded_cnt_q <= ded_cnt_q + CNT_W'(1);
      if (out_ded_q && !ded_seen_q) begin
        ded_seen_q <= 1'b1;
        ded_addr_q <= out_addr_q;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_addr     = out_addr_q;
  assign out_sec      = out_sec_q;
  assign out_ded      = out_ded_q;
  assign out_syndrome = out_syn_q;
  assign sec_count    = sec_cnt_q;
  assign ded_count    = ded_cnt_q;
  assign ded_seen     = ded_seen_q;
  assign ded_addr     = ded_addr_q;

endmodule

// File: tb/tb_secded_dec_72_64.sv
// Bench for secded_dec_72_64: directed vector table, backpressure, saturation/clear/reset
// sequences and randomized traffic scored against a position-array reference model.
module tb_secded_dec_72_64;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;
  localparam int EW     = 90;  // {addr16, syndrome8, sec, ded, data64}

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [71:0]       DatatoDecoder;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_sec;
  logic              out_ded;
  logic [7:0]        out_syndrome;
  logic              cnt_clr;
  logic [CNT_W-1:0]  sec_count;
  logic [CNT_W-1:0]  ded_count;
  logic              ded_seen;
  logic [ADDR_W-1:0] ded_addr;

  secded_dec_72_64 #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .DatatoDecoder(DatatoDecoder), .in_addr(in_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_sec(out_sec),
    .out_ded(out_ded), .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
    .sec_count(sec_count), .ded_count(ded_count), .ded_seen(ded_seen), .ded_addr(ded_addr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_pow2(input int x);
    return (x & (x - 1)) == 0;
  endfunction

  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [6:0] acc;
    int         k;
    acc = '0;
    k   = 0;
    for (int pos = 1; pos < 72; pos++) begin
      if (!is_pow2(pos)) begin
        if (d[k]) acc = acc ^ 7'(pos);
        k++;
      end
    end
    return {(^d) ^ (^acc), acc, d};
  endfunction

  function automatic logic [EW-1:0] ref_decode(input logic [71:0] w, input logic [15:0] a);
    logic        cw[72];
    int          k, j, s;
    logic        p, sec, ded;
    logic [63:0] d;
    for (int pos = 0; pos < 72; pos++) cw[pos] = 1'b0;
    k = 0;
    j = 0;
    for (int pos = 1; pos < 72; pos++) begin
      if (is_pow2(pos)) begin cw[pos] = w[64 + j]; j++; end
      else begin cw[pos] = w[k]; k++; end
    end
    s = 0;
    for (int pos = 1; pos < 72; pos++) if (cw[pos]) s = s ^ pos;
    p   = ^w;
    sec = p && (s <= 71);
    ded = (p && (s > 71)) || (!p && (s != 0));
    if (sec && (s != 0)) cw[s] = !cw[s];
    k = 0;
    for (int pos = 1; pos < 72; pos++) begin
      if (!is_pow2(pos)) begin d[k] = cw[pos]; k++; end
    end
    return {a, p, 7'(s), sec, ded, d};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] e;
  int            inflight = 0;
  int            m_sec = 0;
  int            m_ded = 0;
  logic          m_seen = 1'b0;
  logic [15:0]   m_addr = '0;
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out;
  logic          xfer, acc, have_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      inflight   = 0;
      m_sec      = 0;
      m_ded      = 0;
      m_seen     = 1'b0;
      m_addr     = '0;
      prev_stall = 1'b0;
    end else begin
      chk("sec_count", 128'(sec_count), 128'(m_sec));
      chk("ded_count", 128'(ded_count), 128'(m_ded));
      chk("ded_seen", 128'(ded_seen), 128'(m_seen));
      chk("ded_addr", 128'(ded_addr), 128'(m_addr));
      chk("in_ready", 128'(in_ready), 128'(!(inflight == 2 && !out_ready)));
      if (prev_stall)
        chk("stall_hold", 128'({out_valid, out_addr, out_syndrome, out_sec, out_ded, out_data}),
            128'({1'b1, prev_out}));
      xfer   = out_valid && out_ready;
      acc    = in_valid && in_ready;
      have_e = 1'b0;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data %0h with empty expected queue", out_data);
        end else begin
          e      = exp_q.pop_front();
          have_e = 1'b1;
          chk("out_word", 128'({out_addr, out_syndrome, out_sec, out_ded, out_data}), 128'(e));
        end
      end
      if (cnt_clr) begin
        m_sec = 0; m_ded = 0; m_seen = 1'b0; m_addr = '0;
      end else if (have_e) begin
        if (e[65] && m_sec < 15) m_sec++;
        if (e[64] && m_ded < 15) m_ded++;
        if (e[64] && !m_seen) begin m_seen = 1'b1; m_addr = e[89:74]; end
      end
      if (acc) exp_q.push_back(ref_decode(DatatoDecoder, in_addr));
      inflight   = inflight + int'(acc) - int'(xfer);
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_addr, out_syndrome, out_sec, out_ded, out_data};
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [63:0] d;
    logic [7:0]  c;
    logic [63:0] xd;
    logic        xs;
    logic        xe;
    logic [7:0]  xsyn;
  } vec_t;

  vec_t          vt[10];
  int            sec_acc, ded_acc, recv, sent, saw_low, nerr, outs;
  logic          first_ded, hold, acc_d, xf_d;
  logic [15:0]   first_addr;
  logic [71:0]   w;
  logic [71:0]   words[8];

  initial begin
    vt[0] = '{64'h0, 8'h00, 64'h0, 1'b0, 1'b0, 8'h00};
    vt[1] = '{64'h1, 8'h00, 64'h0, 1'b1, 1'b0, 8'h83};
    vt[2] = '{64'h3, 8'h00, 64'h3, 1'b0, 1'b1, 8'h06};
    vt[3] = '{64'h0, 8'h80, 64'h0, 1'b1, 1'b0, 8'h80};
    vt[4] = '{64'h0100_0000_0000_0000, 8'hC0, 64'h0100_0000_0000_0000, 1'b0, 1'b1, 8'hFF};
    vt[5] = '{64'h0, 8'h01, 64'h0, 1'b1, 1'b0, 8'h81};
    vt[6] = '{64'h8000_0000_0000_0000, 8'h00, 64'h0, 1'b1, 1'b0, 8'hC7};
    vt[7] = '{64'h1, 8'h83, 64'h1, 1'b0, 1'b0, 8'h00};
    vt[8] = '{64'h3, 8'h83, 64'h1, 1'b1, 1'b0, 8'h85};
    vt[9] = '{64'h0, 8'hC8, 64'h0, 1'b0, 1'b1, 8'hC8};

    rst_n = 1'b0; in_valid = 1'b0; DatatoDecoder = '0; in_addr = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    step(); step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_addr", 128'(out_addr), 128'(0));
    chk("rst_out_flags", 128'({out_sec, out_ded, out_syndrome}), 128'(0));
    chk("rst_counters", 128'({sec_count, ded_count, ded_seen, ded_addr}), 128'(0));
    rst_n = 1'b1;
    step();

    sec_acc = 0; ded_acc = 0; first_ded = 1'b0; first_addr = '0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; DatatoDecoder = {vt[i].c, vt[i].d}; in_addr = 16'h100 + 16'(i);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat1_out_valid", 128'(out_valid), 128'(0));
      step();
      chk("vec_out_valid", 128'(out_valid), 128'(1));
      chk("vec_out_data", 128'(out_data), 128'(vt[i].xd));
      chk("vec_out_addr", 128'(out_addr), 128'(16'h100 + 16'(i)));
      chk("vec_flags", 128'({out_sec, out_ded}), 128'({vt[i].xs, vt[i].xe}));
      chk("vec_syndrome", 128'(out_syndrome), 128'(vt[i].xsyn));
      step();
      sec_acc += int'(vt[i].xs);
      ded_acc += int'(vt[i].xe);
      if (vt[i].xe && !first_ded) begin first_ded = 1'b1; first_addr = 16'h100 + 16'(i); end
      chk("vec_sec_count", 128'(sec_count), 128'(sec_acc));
      chk("vec_ded_count", 128'(ded_count), 128'(ded_acc));
      chk("vec_ded_sticky", 128'({ded_seen, ded_addr}), 128'({first_ded, first_addr}));
    end

    // Backpressure: 8 distinct words, out_ready pattern 1,0,0,1,0,0,...
    for (int k = 0; k < 8; k++) words[k] = encode({$urandom, $urandom}) ^ (72'(k & 1) << (k * 9));
    sent = 0; recv = 0; saw_low = 0;
    for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
      out_ready     = (cyc % 3 == 0);
      in_valid      = (sent < 8);
      DatatoDecoder = words[(sent < 8) ? sent : 0];
      in_addr       = 16'h200 + 16'(sent);
      #1;
      acc_d = in_valid && in_ready;
      xf_d  = out_valid && out_ready;
      if (!in_ready) saw_low++;
      step();
      sent += int'(acc_d);
      recv += int'(xf_d);
    end
    in_valid = 1'b0;
    chk("bp_received", 128'(recv), 128'(8));
    chk("bp_in_ready_low_seen", 128'(saw_low > 0), 128'(1));

    // Saturation of a 4-bit counter with 20 single-bit errors.
    out_ready = 1'b1; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      w = encode({$urandom, $urandom});
      w[$urandom_range(0, 71)] ^= 1'b1;
      in_valid = 1'b1; DatatoDecoder = w; in_addr = 16'(k);
      step();
    end
    in_valid = 1'b0;
    step(); step(); step();
    chk("sat_sec_count", 128'(sec_count), 128'(15));
    chk("sat_ded_count", 128'(ded_count), 128'(0));

    // Clear on the same edge as an error transfer: clear wins.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    w = encode(64'hDEAD_BEEF_0123_4567) ^ 72'h10;
    in_valid = 1'b1; DatatoDecoder = w; in_addr = 16'h3AA;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_pre_out_sec", 128'({out_valid, out_sec}), 128'(2'b11));
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_sec_count", 128'(sec_count), 128'(0));

    // Randomized traffic with held stimulus while stalled.
    hold = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        w        = encode({$urandom, $urandom});
        nerr     = $urandom_range(0, 3);
        for (int q = 0; q < nerr; q++) w[$urandom_range(0, 71)] ^= 1'b1;
        DatatoDecoder = w;
        in_addr       = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 199) == 0);
      #1;
      hold = in_valid && !in_ready;
      step();
    end
    in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    step(); step(); step(); step();
    chk("drain_queue_empty", 128'(exp_q.size()), 128'(0));

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; DatatoDecoder = encode(64'h1111); in_addr = 16'h501;
    step();
    DatatoDecoder = encode(64'h2222) ^ 72'h4; in_addr = 16'h502;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_out_valid", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_data", 128'(out_data), 128'(0));
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    outs = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) outs++;
    end
    chk("post_rst_no_output", 128'(outs), 128'(0));
    chk("post_rst_counters", 128'({sec_count, ded_count, ded_seen}), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
